// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared width and ALU opcode encodings for the datapath
package datapath_pkg;

   localparam int WIDTH = 32;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHRA = 5'b01000;
   localparam logic [4:0] OP_SHL  = 5'b01001;
   localparam logic [4:0] OP_ROR  = 5'b01010;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;

endpackage

// File: rtl/datapath_if.sv
// rtl/datapath_if.sv - control strobe bundle driven by a control unit into the datapath
// Ports (signals):
//   read, inc_pc, opcode       MDR source select, ALU increment override, ALU op
//   r_in[15:0], r_out[15:0]    GPR load enables / bus drive selects
//   *_in, *_out                special register load enables / bus drive selects
//   mdatain                    memory read data
// Modports: master drives the strobes (control unit), slave receives them (datapath).
interface datapath_if #(
   parameter int WIDTH = datapath_pkg::WIDTH
) ();

   logic             read;
   logic             inc_pc;
   logic [4:0]       opcode;
   logic [15:0]      r_in;
   logic [15:0]      r_out;
   logic             hi_in, lo_in, y_in, z_in, pc_in, ir_in, mar_in, mdr_in, inport_in, c_in;
   logic             hi_out, lo_out, y_out, zhigh_out, zlow_out, pc_out, ir_out, mar_out,
                     mdr_out, inport_out, c_out;
   logic [WIDTH-1:0] mdatain;

   modport master (
      output read, inc_pc, opcode, r_in, r_out,
      output hi_in, lo_in, y_in, z_in, pc_in, ir_in, mar_in, mdr_in, inport_in, c_in,
      output hi_out, lo_out, y_out, zhigh_out, zlow_out, pc_out, ir_out, mar_out,
      output mdr_out, inport_out, c_out, mdatain
   );

   modport slave (
      input read, inc_pc, opcode, r_in, r_out,
      input hi_in, lo_in, y_in, z_in, pc_in, ir_in, mar_in, mdr_in, inport_in, c_in,
      input hi_out, lo_out, y_out, zhigh_out, zlow_out, pc_out, ir_out, mar_out,
      input mdr_out, inport_out, c_out, mdatain
   );

endinterface

// File: rtl/datapath_alu.sv
// rtl/datapath_alu.sv - combinational ALU producing a 64-bit result from Y and the bus
// Ports:
//   a       in  W    operand A (Y register)
//   b       in  W    operand B (bus); b[4:0] is the shift/rotate amount
//   opcode  in  5    operation select
//   inc_pc  in  1    forces result = b + 1 regardless of opcode
//   result  out 2W   zero-extended single-word result, or {hi, lo} for mul/div
module datapath_alu
   import datapath_pkg::*;
#(
   parameter int W = WIDTH
) (
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic [4:0]     opcode,
   input  logic           inc_pc,
   output logic [2*W-1:0] result
);

   logic [4:0]            amt;
   logic [2*W-1:0]        a_dbl;
   logic [2*W-1:0]        rot_r;
   logic [2*W-1:0]        rot_l;
   logic [W-1:0]          sra;
   logic signed [2*W-1:0] prod;
   logic signed [W-1:0]   quot;
   logic signed [W-1:0]   rem;

   always_comb begin
      amt   = b[4:0];
      // Rotates fall out of shifting a doubled copy of the operand.
      a_dbl = {a, a};
      rot_r = a_dbl >> amt;
      rot_l = a_dbl << amt;
      sra   = $signed(a) >>> amt;
      prod  = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
      quot  = '0;
      rem   = '0;
      // Guarded so a zero divisor never reaches the divider.
      if (b != '0) begin
         quot = $signed(a) / $signed(b);
         rem  = $signed(a) % $signed(b);
      end

      result = '0;
      if (inc_pc) begin
         result = {{W{1'b0}}, b + W'(1)};
      end else begin
         case (opcode)
            OP_ADD:  result = {{W{1'b0}}, a + b};
            OP_SUB:  result = {{W{1'b0}}, a - b};
            OP_AND:  result = {{W{1'b0}}, a & b};
            OP_OR:   result = {{W{1'b0}}, a | b};
            OP_SHR:  result = {{W{1'b0}}, a >> amt};
            OP_SHRA: result = {{W{1'b0}}, sra};
            OP_SHL:  result = {{W{1'b0}}, a << amt};
            OP_ROR:  result = {{W{1'b0}}, rot_r[W-1:0]};
            OP_ROL:  result = {{W{1'b0}}, rot_l[2*W-1:W]};
            OP_MUL:  result = prod;
            OP_DIV:  result = (b == '0) ? {a, {W{1'b1}}} : {rem, quot};
            OP_NEG:  result = {{W{1'b0}}, W'(0) - b};
            OP_NOT:  result = {{W{1'b0}}, ~b};
            default: result = '0;
         endcase
      end
   end

endmodule

// File: rtl/datapath.sv
// rtl/datapath.sv - single-bus CPU datapath: GPRs, special registers, bus mux and ALU
// Ports:
//   Clock, clear        rising-edge clock, synchronous active-high reset
//   Read, IncPC, opcode MDR source select, ALU increment override, ALU op
//   R0in..R15in, HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Inportin, Cin   load enables
//   R0out..R15out, HIout, LOout, Yout, Zhighout, Zlowout, PCout, IRout, MARout,
//   MDRout, Inportout, Cout                                                    bus drive selects
//   Mdatain             memory read data
// No outputs; state is observed hierarchically.
module datapath #(
   parameter int WIDTH = datapath_pkg::WIDTH
) (
   input logic             Clock,
   input logic             clear,
   input logic             Read,
   input logic             IncPC,
   input logic [4:0]       opcode,
   input logic             R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
   input logic             R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
   input logic             HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Inportin, Cin,
   input logic             R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
   input logic             R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
   input logic             HIout, LOout, Yout, Zhighout, Zlowout, PCout, IRout, MARout,
   input logic             MDRout, Inportout, Cout,
   input logic [WIDTH-1:0] Mdatain
);

   logic [15:0]          r_in_v;
   logic [15:0]          r_out_v;
   logic [WIDTH-1:0]     bus_mux_out;
   logic [2*WIDTH-1:0]   alu_result;

   logic [WIDTH-1:0]     r_q [16];
   logic [WIDTH-1:0]     r_d [16];
   logic [WIDTH-1:0]     hi_q, lo_q, y_q, pc_q, ir_q, mar_q, mdr_q, inport_q, c_q;
   logic [WIDTH-1:0]     hi_d, lo_d, y_d, pc_d, ir_d, mar_d, mdr_d, inport_d, c_d;
   logic [2*WIDTH-1:0]   z_q, z_d;

   assign r_in_v  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                     R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
   assign r_out_v = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                     R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

   // Fixed-priority bus mux; lowest GPR index wins, then the special registers in order.
   always_comb begin
      bus_mux_out = '0;
      if (r_out_v != '0) begin
         for (int i = 15; i >= 0; i--) begin
            if (r_out_v[i]) bus_mux_out = r_q[i];
         end
      end
      else if (HIout)     bus_mux_out = hi_q;
      else if (LOout)     bus_mux_out = lo_q;
      else if (Yout)      bus_mux_out = y_q;
      else if (Zhighout)  bus_mux_out = z_q[2*WIDTH-1:WIDTH];
      else if (Zlowout)   bus_mux_out = z_q[WIDTH-1:0];
      else if (PCout)     bus_mux_out = pc_q;
      else if (IRout)     bus_mux_out = ir_q;
      else if (MARout)    bus_mux_out = mar_q;
      else if (MDRout)    bus_mux_out = mdr_q;
      else if (Inportout) bus_mux_out = inport_q;
      else if (Cout)      bus_mux_out = c_q;
   end

   datapath_alu #(.W(WIDTH)) u_alu (
      .a      (y_q),
      .b      (bus_mux_out),
      .opcode (opcode),
      .inc_pc (IncPC),
      .result (alu_result)
   );

   always_comb begin
      for (int i = 0; i < 16; i++) begin
         r_d[i] = r_in_v[i] ? bus_mux_out : r_q[i];
      end
      hi_d     = HIin     ? bus_mux_out : hi_q;
      lo_d     = LOin     ? bus_mux_out : lo_q;
      y_d      = Yin      ? bus_mux_out : y_q;
      pc_d     = PCin     ? bus_mux_out : pc_q;
      ir_d     = IRin     ? bus_mux_out : ir_q;
      mar_d    = MARin    ? bus_mux_out : mar_q;
      inport_d = Inportin ? bus_mux_out : inport_q;
      c_d      = Cin      ? bus_mux_out : c_q;
      mdr_d    = MDRin    ? (Read ? Mdatain : bus_mux_out) : mdr_q;
      z_d      = Zin      ? alu_result : z_q;
   end

   always_ff @(posedge Clock) begin
      if (clear) begin
         for (int i = 0; i < 16; i++) r_q[i] <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         y_q      <= '0;
         pc_q     <= '0;
         ir_q     <= '0;
         mar_q    <= '0;
         mdr_q    <= '0;
         inport_q <= '0;
         c_q      <= '0;
         z_q      <= '0;
      end else begin
         for (int i = 0; i < 16; i++) r_q[i] <= r_d[i];
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         y_q      <= y_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         mar_q    <= mar_d;
         mdr_q    <= mdr_d;
         inport_q <= inport_d;
         c_q      <= c_d;
         z_q      <= z_d;
      end
   end

endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - self-checking bench for datapath against a behavioural ALU/register model
module tb_datapath;
   import datapath_pkg::*;

   logic clk = 1'b0;
   logic clear;
   int   n_checks = 0;
   int   n_errs   = 0;

   datapath_if cif ();

   datapath dut (
      .Clock(clk), .clear(clear), .Read(cif.read), .IncPC(cif.inc_pc), .opcode(cif.opcode),
      .R0in(cif.r_in[0]),   .R1in(cif.r_in[1]),   .R2in(cif.r_in[2]),   .R3in(cif.r_in[3]),
      .R4in(cif.r_in[4]),   .R5in(cif.r_in[5]),   .R6in(cif.r_in[6]),   .R7in(cif.r_in[7]),
      .R8in(cif.r_in[8]),   .R9in(cif.r_in[9]),   .R10in(cif.r_in[10]), .R11in(cif.r_in[11]),
      .R12in(cif.r_in[12]), .R13in(cif.r_in[13]), .R14in(cif.r_in[14]), .R15in(cif.r_in[15]),
      .HIin(cif.hi_in), .LOin(cif.lo_in), .Yin(cif.y_in), .Zin(cif.z_in), .PCin(cif.pc_in),
      .IRin(cif.ir_in), .MARin(cif.mar_in), .MDRin(cif.mdr_in), .Inportin(cif.inport_in),
      .Cin(cif.c_in),
      .R0out(cif.r_out[0]),   .R1out(cif.r_out[1]),   .R2out(cif.r_out[2]),   .R3out(cif.r_out[3]),
      .R4out(cif.r_out[4]),   .R5out(cif.r_out[5]),   .R6out(cif.r_out[6]),   .R7out(cif.r_out[7]),
      .R8out(cif.r_out[8]),   .R9out(cif.r_out[9]),   .R10out(cif.r_out[10]), .R11out(cif.r_out[11]),
      .R12out(cif.r_out[12]), .R13out(cif.r_out[13]), .R14out(cif.r_out[14]), .R15out(cif.r_out[15]),
      .HIout(cif.hi_out), .LOout(cif.lo_out), .Yout(cif.y_out), .Zhighout(cif.zhigh_out),
      .Zlowout(cif.zlow_out), .PCout(cif.pc_out), .IRout(cif.ir_out), .MARout(cif.mar_out),
      .MDRout(cif.mdr_out), .Inportout(cif.inport_out), .Cout(cif.c_out),
      .Mdatain(cif.mdatain)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic idle();
      clear = 1'b0;
      cif.read = 0; cif.inc_pc = 0; cif.opcode = '0; cif.r_in = '0; cif.r_out = '0;
      cif.hi_in = 0; cif.lo_in = 0; cif.y_in = 0; cif.z_in = 0; cif.pc_in = 0;
      cif.ir_in = 0; cif.mar_in = 0; cif.mdr_in = 0; cif.inport_in = 0; cif.c_in = 0;
      cif.hi_out = 0; cif.lo_out = 0; cif.y_out = 0; cif.zhigh_out = 0; cif.zlow_out = 0;
      cif.pc_out = 0; cif.ir_out = 0; cif.mar_out = 0; cif.mdr_out = 0; cif.inport_out = 0;
      cif.c_out = 0; cif.mdatain = '0;
   endtask

   // Apply whatever strobes are set across one rising edge, then release them.
   task automatic cycle();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic load_mdr(input logic [31:0] v);
      cif.read = 1; cif.mdr_in = 1; cif.mdatain = v;
      cycle();
   endtask

   task automatic load_reg(input int idx, input logic [31:0] v);
      load_mdr(v);
      cif.mdr_out = 1; cif.r_in[idx] = 1;
      cycle();
   endtask

   // Y <= a, then Z <= ALU(Y, b).
   task automatic alu_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] op, input logic inc);
      load_mdr(a);
      cif.mdr_out = 1; cif.y_in = 1;
      cycle();
      load_mdr(b);
      cif.mdr_out = 1; cif.opcode = op; cif.inc_pc = inc; cif.z_in = 1;
      cycle();
   endtask

   function automatic logic [63:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] op, input logic inc);
      longint      sa, sb, q, r;
      logic [31:0] w;
      int          n;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      n  = int'(b[4:0]);
      if (inc) begin
         w = b + 32'd1;
         return {32'd0, w};
      end
      case (op)
         5'd3:  w = a + b;
         5'd4:  w = a - b;
         5'd5:  w = a & b;
         5'd6:  w = a | b;
         5'd7:  w = a >> n;
         5'd8:  begin q = sa >>> n; w = q[31:0]; end
         5'd9:  w = a << n;
         5'd10: begin w = a; for (int k = 0; k < n; k++) w = {w[0], w[31:1]}; end
         5'd11: begin w = a; for (int k = 0; k < n; k++) w = {w[30:0], w[31]}; end
         5'd15: return 64'(sa * sb);
         5'd16: begin
            if (b == 32'd0) return {a, 32'hFFFFFFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         5'd17: w = 32'd0 - b;
         5'd18: w = ~b;
         default: w = 32'd0;
      endcase
      return {32'd0, w};
   endfunction

   logic [4:0]  op_list [13];
   logic [31:0] m [16];
   logic [31:0] a, b;
   logic [4:0]  op;
   logic        inc;
   int          src, dst;

   initial begin
      op_list = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
                  OP_ROR, OP_ROL, OP_MUL, OP_DIV, OP_NEG, OP_NOT};
      idle();
      clear = 1;
      cycle();
      check_eq("reset_pc", 64'(dut.pc_q), 64'd0);
      check_eq("reset_z", dut.z_q, 64'd0);
      check_eq("reset_r15", 64'(dut.r_q[15]), 64'd0);
      check_eq("reset_mdr", 64'(dut.mdr_q), 64'd0);

      // Instruction fetch from reset.
      cif.pc_out = 1; cif.mar_in = 1; cif.inc_pc = 1; cif.z_in = 1;
      cycle();
      check_eq("fetch_mar", 64'(dut.mar_q), 64'd0);
      check_eq("fetch_z", dut.z_q, 64'd1);
      cif.zlow_out = 1; cif.pc_in = 1; cif.read = 1; cif.mdr_in = 1;
      cif.mdatain = 32'h81180000;
      cycle();
      check_eq("fetch_pc", 64'(dut.pc_q), 64'd1);
      check_eq("fetch_mdr", 64'(dut.mdr_q), 64'h81180000);
      cif.mdr_out = 1; cif.ir_in = 1;
      cycle();
      check_eq("fetch_ir", 64'(dut.ir_q), 64'h81180000);

      // 13 / 3 through GPRs into LO/HI.
      load_reg(2, 32'd13);
      load_reg(3, 32'd3);
      cif.r_out[2] = 1; cif.y_in = 1;
      cycle();
      cif.r_out[3] = 1; cif.opcode = OP_DIV; cif.z_in = 1;
      cycle();
      cif.zlow_out = 1; cif.lo_in = 1;
      cycle();
      cif.zhigh_out = 1; cif.hi_in = 1;
      cycle();
      check_eq("div_lo", 64'(dut.lo_q), 64'd4);
      check_eq("div_hi", 64'(dut.hi_q), 64'd1);

      alu_op(-32'sd6, 32'd7, OP_MUL, 0);
      check_eq("mul_neg", dut.z_q, 64'hFFFFFFFF_FFFFFFD6);
      alu_op(-32'sd13, 32'd3, OP_DIV, 0);
      check_eq("div_neg", dut.z_q, 64'hFFFFFFFF_FFFFFFFC);
      alu_op(32'd9, 32'd0, OP_DIV, 0);
      check_eq("div_zero", dut.z_q, 64'h00000009_FFFFFFFF);
      alu_op(32'h80000001, 32'd1, OP_SHR, 0);
      check_eq("shr", dut.z_q, 64'h40000000);
      alu_op(32'h80000001, 32'd1, OP_SHRA, 0);
      check_eq("shra", dut.z_q, 64'hC0000000);
      alu_op(32'h80000001, 32'd1, OP_ROL, 0);
      check_eq("rol", dut.z_q, 64'h00000003);
      alu_op(32'h80000001, 32'd1, OP_ROR, 0);
      check_eq("ror", dut.z_q, 64'hC0000000);

      // Randomised ALU operations against the reference model.
      for (int t = 0; t < 80; t++) begin
         a   = $urandom();
         b   = $urandom();
         inc = ($urandom_range(0, 7) == 0);
         op  = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 31))
                                           : op_list[$urandom_range(0, 12)];
         if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(0, 40));
         if (op == OP_DIV && $urandom_range(0, 3) == 0) b = 32'd0;
         if (op == OP_DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
         alu_op(a, b, op, inc);
         check_eq($sformatf("alu op=%0d inc=%0d a=%h b=%h", op, inc, a, b),
                  dut.z_q, alu_ref(a, b, op, inc));
      end

      // Random register-to-register moves against a register-file model.
      for (int i = 0; i < 16; i++) begin
         m[i] = $urandom();
         load_reg(i, m[i]);
      end
      for (int t = 0; t < 30; t++) begin
         src = $urandom_range(0, 15);
         dst = $urandom_range(0, 15);
         cif.r_out[src] = 1; cif.r_in[dst] = 1;
         #1;
         check_eq($sformatf("bus_r%0d", src), 64'(dut.bus_mux_out), 64'(m[src]));
         cycle();
         m[dst] = m[src];
         check_eq($sformatf("move_r%0d_r%0d", src, dst), 64'(dut.r_q[dst]), 64'(m[dst]));
      end

      // Bus priority and idle bus.
      load_mdr(32'hA5A5_0001);
      cif.mdr_out = 1; cif.hi_in = 1;
      cycle();
      load_mdr(32'h5A5A_0002);
      cif.mdr_out = 1; cif.lo_in = 1;
      cycle();
      cif.r_out[7] = 1; cif.r_out[9] = 1; cif.hi_out = 1;
      #1;
      check_eq("prio_r7", 64'(dut.bus_mux_out), 64'(m[7]));
      idle();
      cif.hi_out = 1; cif.lo_out = 1; cif.mdr_out = 1;
      #1;
      check_eq("prio_hi", 64'(dut.bus_mux_out), 64'hA5A5_0001);
      idle();
      cif.lo_out = 1; cif.mdr_out = 1;
      #1;
      check_eq("prio_lo", 64'(dut.bus_mux_out), 64'h5A5A_0002);
      idle();
      #1;
      check_eq("bus_idle", 64'(dut.bus_mux_out), 64'd0);

      // Clear overrides loads in flight.
      load_mdr(32'hDEAD_BEEF);
      clear = 1; cif.r_in[5] = 1; cif.mdr_out = 1;
      cycle();
      check_eq("clear_r5", 64'(dut.r_q[5]), 64'd0);
      check_eq("clear_r0", 64'(dut.r_q[0]), 64'd0);
      check_eq("clear_mdr", 64'(dut.mdr_q), 64'd0);
      check_eq("clear_hi", 64'(dut.hi_q), 64'd0);
      check_eq("clear_z", dut.z_q, 64'd0);
      check_eq("clear_y", 64'(dut.y_q), 64'd0);
      check_eq("clear_ir", 64'(dut.ir_q), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
